// File: rtl/romload_sched.sv
// romload_sched: routes the MiSTer ROM download stream into four ROM regions,
// holds the game core in reset until a complete image has arrived, and then
// shares the ROM write port with a low-priority patch requester.
// Optional feature macro: ROMLOAD_PATCH_EN enables the patch port and its
// RUN-state arbitration; without it the pt_* inputs are ignored and pt_ack is 0.
module romload_sched #(
  parameter int unsigned R0_END   = 'h0C000,
  parameter int unsigned R1_END   = 'h10000,
  parameter int unsigned R2_END   = 'h20000,
  parameter int unsigned R3_END   = 'h20220,
  parameter int unsigned HOLD_CYC = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        pt_req,
  input  logic [1:0]  pt_region,
  input  logic [16:0] pt_addr,
  input  logic [7:0]  pt_data,
  output logic        pt_ack,
  output logic [3:0]  rom_we,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        rom_ok,
  output logic        rom_short
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t      state_q;
  state_t      state_d;
  logic        dl_active_q;
  logic        dl_rise;
  logic        dl_fall;
  logic [17:0] byte_cnt;
  logic [7:0]  hold_cnt;
  logic        img_complete;
  logic        rom_ok_q;
  logic        rom_short_q;
  logic        core_reset_c;

  logic [3:0]  dl_sel;
  logic [16:0] dl_off;
  logic        dl_wr_ok;
  logic        pt_grant;

  logic [3:0]  we_p1;
  logic [16:0] addr_p1;
  logic [7:0]  data_p1;

  assign dl_rise      = dl_active & ~dl_active_q;
  assign dl_fall      = ~dl_active & dl_active_q;
  assign img_complete = (byte_cnt == 18'(R3_END));

  // Region decode: first region whose exclusive end lies above the address.
  always_comb begin
    dl_sel = 4'b0000;
    dl_off = '0;
    if (dl_addr < 25'(R0_END)) begin
      dl_sel = 4'b0001;
      dl_off = 17'(dl_addr);
    end else if (dl_addr < 25'(R1_END)) begin
      dl_sel = 4'b0010;
      dl_off = 17'(dl_addr - 25'(R0_END));
    end else if (dl_addr < 25'(R2_END)) begin
      dl_sel = 4'b0100;
      dl_off = 17'(dl_addr - 25'(R1_END));
    end else if (dl_addr < 25'(R3_END)) begin
      dl_sel = 4'b1000;
      dl_off = 17'(dl_addr - 25'(R2_END));
    end
  end

  // Bytes beyond the image end decode to no region and are dropped uncounted.
  assign dl_wr_ok = (state_q == LOAD) && dl_wr && (dl_sel != 4'b0000);

`ifdef ROMLOAD_PATCH_EN
  logic       ack_p1;
  logic [3:0] pt_sel;

  // A new download outranks a patch request raised in the same cycle, and a
  // grant is never issued in the cycle that carries the previous ack.
  assign pt_grant = (state_q == RUN) && pt_req && !ack_p1 && !dl_rise;
  assign pt_sel   = 4'b0001 << pt_region;

  // Ack register: pulses together with the patch write strobe.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) ack_p1 <= 1'b0;
    else          ack_p1 <= pt_grant;
  end

  assign pt_ack = ack_p1;
`else
  logic unused_pt;

  assign pt_grant  = 1'b0;
  assign unused_pt = ^{pt_req, pt_region, pt_addr, pt_data};
  assign pt_ack    = 1'b0;
`endif

  // State register and control counters.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dl_active_q <= 1'b0;
      byte_cnt    <= '0;
      hold_cnt    <= '0;
      rom_ok_q    <= 1'b0;
      rom_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_active_q <= dl_active;
      hold_cnt    <= (state_q == HOLD) ? hold_cnt + 8'd1 : 8'd0;
      if (state_d == LOAD && state_q != LOAD) begin
        byte_cnt    <= '0;
        rom_ok_q    <= 1'b0;
        rom_short_q <= 1'b0;
      end else begin
        if (dl_wr_ok && byte_cnt != '1) byte_cnt <= byte_cnt + 18'd1;
        if (state_q == LOAD && dl_fall) begin
          if (img_complete) rom_ok_q    <= 1'b1;
          else              rom_short_q <= 1'b1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dl_rise) state_d = LOAD;
      LOAD: if (dl_fall) state_d = img_complete ? HOLD : IDLE;
      HOLD: begin
        if (dl_rise)                               state_d = LOAD;
        else if (hold_cnt == 8'(HOLD_CYC - 1))     state_d = RUN;
      end
      RUN:  if (dl_rise) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: the core only runs once the hold window has elapsed.
  always_comb begin
    core_reset_c = 1'b1;
    if (state_q == RUN) core_reset_c = 1'b0;
  end

  // Stage p1: registered ROM write port, fed by download or granted patch.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      we_p1   <= '0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (dl_wr_ok) begin
      we_p1   <= dl_sel;
      addr_p1 <= dl_off;
      data_p1 <= dl_data;
    end
`ifdef ROMLOAD_PATCH_EN
    else if (pt_grant) begin
      we_p1   <= pt_sel;
      addr_p1 <= pt_addr;
      data_p1 <= pt_data;
    end
`endif
    else begin
      we_p1 <= '0;
    end
  end

  assign rom_we     = we_p1;
  assign rom_addr   = addr_p1;
  assign rom_data   = data_p1;
  assign core_reset = core_reset_c;
  assign rom_ok     = rom_ok_q;
  assign rom_short  = rom_short_q;

endmodule

// File: doc/romload_sched.md
# romload_sched

Sequences the MiSTer ROM download stream into the game core's ROM regions. It decodes the flat download address into one of four region write strobes with region-relative addresses, and holds the game core in reset until a complete image has arrived. Once the image is complete it shares the same ROM write port with a low-priority patch requester (cheat/hiscore writer). It sits between `hps_io` and `FPGA_GreenBeret`, in the `clk_sys` domain.

## Interface
Parameters:
- R0_END, 'h0C000, exclusive end of region 0 (program ROM); region 0 starts at 0
- R1_END, 'h10000, exclusive end of region 1 (char ROM)
- R2_END, 'h20000, exclusive end of region 2 (sprite ROM)
- R3_END, 'h20220, exclusive end of region 3 (PROMs); also the total image size
- HOLD_CYC, 16, cycles core_reset stays high after a complete download ends (1..255)

Ports:
- clk_sys  in  1  system clock (48 MHz)
- reset_n  in  1  synchronous, active-low reset
- dl_active  in  1  download in progress (`ioctl_download`)
- dl_wr  in  1  download byte strobe (`ioctl_wr`)
- dl_addr  in  25  download byte address
- dl_data  in  8  download byte
- pt_req  in  1  patch write request; level, held until pt_ack
- pt_region  in  2  patch target region
- pt_addr  in  17  patch region-relative address
- pt_data  in  8  patch byte
- pt_ack  out  1  one-cycle grant/complete pulse
- rom_we  out  4  one-hot region write strobe
- rom_addr  out  17  region-relative address
- rom_data  out  8  write data
- core_reset  out  1  active-high reset to the game core
- rom_ok  out  1  last download was complete
- rom_short  out  1  last download ended with fewer than R3_END bytes

## Operation
- States: IDLE, LOAD, HOLD, RUN. Reset enters IDLE with core_reset=1, rom_ok=0, rom_short=0, rom_we=0, pt_ack=0, rom_addr=0, rom_data=0, byte counter=0, hold counter=0.
- IDLE: core_reset=1. Rising edge of dl_active goes to LOAD.
- LOAD: core_reset=1. Entry clears the counter, rom_ok and rom_short. Each dl_wr with dl_addr<R3_END produces one write, counter+1.
  - Region select: first bound with addr < Rn_END. rom_addr = dl_addr − start of that region, truncated to 17 bits.
  - dl_wr with dl_addr ≥ R3_END is dropped and not counted.
  - Falling edge of dl_active: if counter==R3_END, set rom_ok and go to HOLD. Otherwise set rom_short and go to IDLE, so the core stays in reset.
- HOLD: core_reset=1 for exactly HOLD_CYC cycles, then RUN. A dl_active rise here aborts to LOAD.
- RUN: core_reset=0. pt_req is granted when no pt_ack was issued the previous cycle: one write to pt_region and pt_addr, with pt_ack pulsed. A dl_active rise goes to LOAD with priority over a same-cycle pt_req, and that request is not acked.
- Counter is 18 bits and saturates at its max value.
- Duplicate addresses are counted as separate writes; completeness means byte count only.

## Timing
- Download write: rom_we/rom_addr/rom_data are registered, 1 cycle after dl_wr. rom_we is high for 1 cycle per dl_wr.
- Patch write: the grant cycle is N (pt_req sampled high in RUN). rom_we and pt_ack are both high in N+1. Max throughput is one patch write every 2 cycles.
- core_reset falls HOLD_CYC+1 cycles after the dl_active falling edge (1 cycle to detect the edge, then HOLD_CYC).
- rom_ok/rom_short update 1 cycle after the dl_active falling edge.
- reset_n low in any state returns to IDLE next edge. An in-flight rom_we is cancelled.

## Configuration
- ROMLOAD_PATCH_EN
  - Defined: patch port and RUN-state arbitration present as above.
  - Undefined: pt_req/pt_region/pt_addr/pt_data are ignored, pt_ack is tied 0, and rom_we is driven only by the download path.

## Test plan
- Full download: 'h20220 sequential bytes then dl_active fall. Required: byte 'h0BFFF gives rom_we=0001 with rom_addr='h0BFFF; byte 'h0C000 gives rom_we=0010 with rom_addr=0; byte 'h20000 gives rom_we=1000 with rom_addr=0. rom_ok=1, and core_reset falls 17 cycles after the fall.
- Short download: 'h1FFFF bytes. Required: rom_short=1, rom_ok=0, core_reset stays 1, state IDLE.
- Out-of-range: writes at 'h20220 and 'h30000 during a full download. Required: no rom_we, rom_ok still 1.
- Patch in RUN: pt_req with region 2, addr 'h00123, data 'hA5. Required: next cycle rom_we=0100, rom_addr='h00123, rom_data='hA5, pt_ack=1. Back-to-back requests are acked every 2 cycles.
- Conflict: pt_req and dl_active rise in the same RUN cycle. Required: no pt_ack, LOAD entered, core_reset=1, rom_ok cleared.
- Reset mid-LOAD: reset_n low after 100 bytes. Required: IDLE, all outputs at reset values; a subsequent full download yields rom_ok=1.
